seq_add64: RTL and testbench
============================

SEQ_ADD64 -- requirements
Module: seq_add64

Interface
REQ-001 N_CHUNK, 4, number of 16-bit chunks; operand width W = 16*N_CHUNK (64 by default).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  W  operand A.
REQ-007 b  input  W  operand B.
REQ-008 cin  input  1  carry-in; ignored when sub=1.
REQ-009 sub  input  1  1 = compute a - b, 0 = compute a + b + cin.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  W  result.
REQ-013 cout  output  1  final carry out; for sub=1, 1 means no borrow.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with rst low; out_valid SHALL be 1 only in DONE.
REQ-017 On in_valid & in_ready, the block SHALL:
- latch a into a_reg and (sub ? ~b : b) into b_reg;
- set carry_reg = (sub ? 1 : cin);
- clear chunk index k to 0 and sum_reg to 0;
- enter RUN.
REQ-018 Each RUN cycle SHALL add chunk k of a_reg and b_reg with carry_reg through one 16-bit adder, write the 16-bit result to sum_reg[16k+15:16k], load the adder's carry out into carry_reg, and increment k.
REQ-019 On the RUN cycle with k = N_CHUNK-1, the block SHALL capture ovf, load cout from that cycle's carry out, and enter DONE.
- ovf = (a_reg[W-1] == b_reg[W-1]) & (result[W-1] != a_reg[W-1]).
REQ-020 Latency SHALL be exactly N_CHUNK cycles: for acceptance at edge T, out_valid rises after edge T+N_CHUNK (default 4).
REQ-021 In DONE, sum, cout and ovf SHALL hold stable until out_ready=1; on out_valid & out_ready the FSM SHALL return to IDLE.
REQ-022 a, b, cin, sub and in_valid SHALL be ignored outside IDLE; operands SHALL NOT change mid-operation.
REQ-023 Throughput SHALL be one result per N_CHUNK+1 cycles minimum; acceptance and result hand-off SHALL never occur in the same cycle.
REQ-024 With N_CHUNK=1, RUN SHALL last exactly one cycle.
REQ-025 All arithmetic SHALL be modulo 2^W; the carry between chunks SHALL propagate only through carry_reg.

Reset
REQ-026 While rst=1 at a clock edge:
- state SHALL become IDLE and k = 0;
- sum, cout, ovf, carry_reg, a_reg and b_reg SHALL become 0;
- out_valid SHALL be 0 and in_ready SHALL be 0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation, discard partial results, and produce no out_valid for it.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-029 A shared package SHALL hold CHUNK_W = 16 and the FSM state enum (IDLE, RUN, DONE).
REQ-030 The datapath SHALL instantiate exactly one CSelectAdder_16bit as the chunk adder; no other arithmetic sub-module is permitted.
REQ-031 Chunk select SHALL be an indexed part-select on k; k width SHALL be clog2(N_CHUNK), minimum 1.

Verification
REQ-032 Carry wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=0, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-033 Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-034 Subtract with borrow: a=5, b=7, sub=1, cin=1 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0; cin ignored.
REQ-035 Inter-chunk carry: a=0x0000_0000_FFFF_FFFF, b=1, cin=0 -> sum=0x0000_0001_0000_0000.
REQ-036 Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands -> sum held, in_ready=0, new operands not taken; one cycle after out_ready=1, in_ready=1.
REQ-037 Mid-run reset: rst=1 for one edge after chunk 1 -> next cycle out_valid=0, sum=0, and in_ready=1 once rst is low; no result is produced for the aborted operation.

Source files
------------

// File: rtl/seq_add64_pkg.sv
// Shared definitions for the chunked sequential adder.
package seq_add64_pkg;

   localparam int unsigned CHUNK_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_add64_csel.sv
// 16-bit carry-select adder used as the per-chunk adder of seq_add64.
// The low byte ripples; the high byte is precomputed for both carry values
// and selected by the low byte's carry out.
module CSelectAdder_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   logic [8:0] lo;
   logic [8:0] hi0;
   logic [8:0] hi1;

   // Both high-byte candidates are formed in parallel with the low byte.
   always_comb begin
      lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
      hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
      hi1 = hi0 + 9'd1;
      sum = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
      cout = lo[8] ? hi1[8] : hi0[8];
   end

endmodule

// File: rtl/seq_add64.sv
// Sequential W-bit adder/subtractor that processes one 16-bit chunk per
// cycle through a single carry-select adder, with valid/ready handshakes.
module seq_add64
   import seq_add64_pkg::*;
#(
   parameter int unsigned N_CHUNK = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHUNK_W*N_CHUNK-1:0]   a,
   input  logic [CHUNK_W*N_CHUNK-1:0]   b,
   input  logic                         cin,
   input  logic                         sub,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHUNK_W*N_CHUNK-1:0]   sum,
   output logic                         cout,
   output logic                         ovf
);

   localparam int unsigned W  = CHUNK_W * N_CHUNK;
   localparam int unsigned KW = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_CHUNK - 1);

   state_t               state;
   logic [W-1:0]         a_reg;
   logic [W-1:0]         b_reg;
   logic [W-1:0]         sum_reg;
   logic                 carry_reg;
   logic                 cout_reg;
   logic                 ovf_reg;
   logic [KW-1:0]        k;

   logic [CHUNK_W-1:0]   a_chunk;
   logic [CHUNK_W-1:0]   b_chunk;
   logic [CHUNK_W-1:0]   chunk_sum;
   logic                 chunk_cout;

   // Current chunk of each operand, selected by the chunk index.
   always_comb begin
      a_chunk = a_reg[k*CHUNK_W +: CHUNK_W];
      b_chunk = b_reg[k*CHUNK_W +: CHUNK_W];
   end

   CSelectAdder_16bit u_chunk_add (
      .a    (a_chunk),
      .b    (b_chunk),
      .cin  (carry_reg),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   // Handshake outputs and result registers.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
      sum       = sum_reg;
      cout      = cout_reg;
      ovf       = ovf_reg;
   end

   // FSM plus datapath: accept operands, walk chunks LSB first, hold result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= sub ? ~b : b;
                  carry_reg <= sub ? 1'b1 : cin;
                  k         <= '0;
                  sum_reg   <= '0;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum_reg[k*CHUNK_W +: CHUNK_W] <= chunk_sum;
               carry_reg <= chunk_cout;
               if (k == K_LAST) begin
                  // The top chunk's MSB is the result sign bit.
                  ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                              (chunk_sum[CHUNK_W-1] != a_reg[W-1]);
                  cout_reg <= chunk_cout;
                  k        <= '0;
                  state    <= DONE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_add64.sv
// Scoreboard bench for seq_add64: the driver pushes expected results at
// acceptance, a separate monitor pops and compares on each result hand-off.
module tb_seq_add64;

   localparam int unsigned N_CHUNK = 4;

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] a = '0;
   logic [63:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] sum;
   logic        cout;
   logic        ovf;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];

   seq_add64 #(.N_CHUNK(N_CHUNK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic issue(input logic [63:0] va, input logic [63:0] vb,
                        input logic vcin, input logic vsub, input bit push,
                        input logic [63:0] esum, input logic ecout, input logic eovf);
      bit got = 0;
      a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            if (push) sb.push_back('{esum, ecout, eovf, cyc + 1});
            got = 1;
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      end
   endtask

   // Monitor: latency on out_valid rise, result compare on hand-off.
   initial begin
      logic ov_prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && !ov_prev && sb.size() > 0) begin
            checks++;
            if (cyc - sb[0].acc != N_CHUNK) begin
               errors++;
               $display("FAIL latency: got %0d expected %0d", cyc - sb[0].acc, N_CHUNK);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_result: got sum=%h expected no result", sum);
            end else begin
               e = sb.pop_front();
               if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
                  errors++;
                  $display("FAIL result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                           sum, cout, ovf, e.sum, e.cout, e.ovf);
               end
            end
         end
         ov_prev = out_valid;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      bit saw;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sum", sum, 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // Directed vectors: a, b, cin, sub -> sum, cout, ovf
      issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1, 64'h0, 1, 0);
      issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 0, 0, 1, 64'h8000_0000_0000_0000, 0, 1);
      issue(64'h5, 64'h7, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);
      issue(64'h0000_0000_FFFF_FFFF, 64'h1, 0, 0, 1, 64'h0000_0001_0000_0000, 0, 0);
      issue(64'h0, 64'h0, 1, 0, 1, 64'h1, 0, 0);
      issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 1, 64'h0, 1, 1);
      issue(64'h8000_0000_0000_0000, 64'h1, 0, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1);
      issue(64'h1234, 64'h1234, 0, 1, 1, 64'h0, 1, 0);
      issue(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1, 0, 1, 64'h0, 1, 0);
      issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 0, 0, 1, 64'h0001_0000_0001_0000, 0, 0);
      issue(64'hA, 64'h3, 0, 1, 1, 64'h7, 1, 0);
      drain();

      // Backpressure: hold result while new operands are offered
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(64'h0000_0000_FFFF_FFFF, 64'h1, 0, 0, 1, 64'h0000_0001_0000_0000, 0, 0);
      saw = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid) begin saw = 1; break; end
      end
      chk("bp_out_valid_seen", 64'(saw), 64'd1);
      @(posedge clk); #1;
      a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_sum_hold", sum, 64'h0000_0001_0000_0000);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("bp_in_ready_after", 64'(in_ready), 64'd1);
      chk("bp_out_valid_after", 64'(out_valid), 64'd0);
      @(posedge clk); #1;

      // Mid-run reset after chunk 1: result must be discarded
      issue(64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 0, 0, 0, 64'h0, 0, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_sum", sum, 64'd0);
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      saw = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) saw = 1;
      end
      chk("abort_no_result", 64'(saw), 64'd0);
      @(posedge clk); #1;

      // Recovery after abort
      issue(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 0, 0, 1, 64'h0000_0000_0001_0000, 0, 0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
